// File: rtl/ex_mem_slave_reg_pkg.sv
// Shared types for the slave-lane execute/memory pipeline register.
// Exception codes, the stage state enum and the pipeline payload struct.
package ex_mem_slave_reg_pkg;

  localparam int SLV_DW = 32;
  localparam int SLV_RW = 5;

  localparam logic [4:0] EXC_OV = 5'h0C;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_HOLD = 1'b1
  } slv_state_e;

  typedef struct packed {
    logic [SLV_DW-1:0] pc;
    logic [SLV_DW-1:0] y;
    logic [SLV_RW-1:0] rd;
    logic              wen;
    logic              exc;
    logic              in_ds;
  } slave_pipe_t;

endpackage

// File: rtl/ex_mem_slave_reg.sv
// Slave-lane EX/MEM pipeline register: 2-entry skid buffer (head H, skid S),
// precise overflow exception with writeback suppression, and a forwarding tap.
module ex_mem_slave_reg #(
  parameter int         DW     = ex_mem_slave_reg_pkg::SLV_DW,
  parameter int         RW     = ex_mem_slave_reg_pkg::SLV_RW,
  parameter logic [4:0] EXC_OV = ex_mem_slave_reg_pkg::EXC_OV
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_pc,
  input  logic [DW-1:0] ex_y,
  input  logic          ex_overflow,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wen,
  input  logic          ex_in_ds,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_pc,
  output logic [DW-1:0] mem_y,
  output logic [RW-1:0] mem_rd,
  output logic          mem_wen,
  output logic          mem_exc,
  output logic [4:0]    mem_excode,
  output logic          mem_in_ds,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data
);

  import ex_mem_slave_reg_pkg::*;

  slave_pipe_t r_h;
  slave_pipe_t r_s;
  logic        r_h_valid;
  logic        r_s_valid;
  slv_state_e  r_state;
  logic        r_ex_ready;

  slave_pipe_t w_h_nxt;
  slave_pipe_t w_s_nxt;
  logic        w_h_valid_nxt;
  logic        w_s_valid_nxt;
  slv_state_e  w_state_nxt;
  slave_pipe_t w_new;
  logic        w_accept;
  logic        w_pop;

  assign w_accept = ex_valid & r_ex_ready & (r_state == RUN);
  assign w_pop    = r_h_valid & mem_ready;

  // The faulting instruction never writes back; its exception travels with it.
  assign w_new = '{pc:    ex_pc,
                   y:     ex_y,
                   rd:    ex_rd,
                   wen:   ex_wen & ~ex_overflow,
                   exc:   ex_overflow,
                   in_ds: ex_in_ds};

  // Next-state for head/skid entries and the exception state machine.
  always_comb begin
    w_h_nxt       = r_h;
    w_s_nxt       = r_s;
    w_h_valid_nxt = r_h_valid;
    w_s_valid_nxt = r_s_valid;
    w_state_nxt   = r_state;
    if (flush) begin
      w_h_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
      w_h_nxt       = '0;
      w_s_nxt       = '0;
      w_state_nxt   = RUN;
    end else begin
      if (w_pop) begin
        if (r_s_valid) begin
          w_h_nxt       = r_s;
          w_h_valid_nxt = 1'b1;
          if (w_accept) begin
            w_s_nxt       = w_new;
            w_s_valid_nxt = 1'b1;
          end else begin
            w_s_valid_nxt = 1'b0;
          end
        end else if (w_accept) begin
          w_h_nxt       = w_new;
          w_h_valid_nxt = 1'b1;
        end else begin
          w_h_valid_nxt = 1'b0;
        end
      end else if (w_accept) begin
        if (!r_h_valid) begin
          w_h_nxt       = w_new;
          w_h_valid_nxt = 1'b1;
        end else if (!r_s_valid) begin
          w_s_nxt       = w_new;
          w_s_valid_nxt = 1'b1;
        end else begin
          w_s_valid_nxt = r_s_valid;
        end
      end else begin
        w_h_valid_nxt = r_h_valid;
      end
      case (r_state)
        RUN: begin
          if (w_accept && ex_overflow) begin
            w_state_nxt = EXC_HOLD;
          end else begin
            w_state_nxt = RUN;
          end
        end
        EXC_HOLD: w_state_nxt = EXC_HOLD;
        default:  w_state_nxt = RUN;
      endcase
    end
  end

  // Pipeline state registers; ex_ready is precomputed from next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_h        <= '0;
      r_s        <= '0;
      r_h_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_state    <= RUN;
      r_ex_ready <= 1'b1;
    end else begin
      r_h        <= w_h_nxt;
      r_s        <= w_s_nxt;
      r_h_valid  <= w_h_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_state    <= w_state_nxt;
      r_ex_ready <= ~w_s_valid_nxt & (w_state_nxt == RUN);
    end
  end

  assign ex_ready   = r_ex_ready;
  assign mem_valid  = r_h_valid;
  assign mem_pc     = r_h.pc;
  assign mem_y      = r_h.y;
  assign mem_rd     = r_h.rd;
  assign mem_wen    = r_h.wen & ~r_h.exc;
  assign mem_exc    = r_h.exc;
  assign mem_excode = r_h.exc ? EXC_OV : 5'h00;
  assign mem_in_ds  = r_h.in_ds;

  // Youngest held entry feeds the issue-stage bypass.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (r_s_valid) begin
      fwd_valid = r_s.wen;
      fwd_rd    = r_s.rd;
      fwd_data  = r_s.y;
    end else begin
      fwd_valid = r_h_valid & r_h.wen;
      fwd_rd    = r_h.rd;
      fwd_data  = r_h.y;
    end
  end

endmodule

// File: tb/tb_ex_mem_slave_reg.sv
// Directed self-checking bench for ex_mem_slave_reg.
module tb_ex_mem_slave_reg;

  logic        clk = 1'b0;
  logic        resetn, flush, ex_valid, ex_ready, ex_overflow, ex_wen, ex_in_ds;
  logic [31:0] ex_pc, ex_y;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_ready, mem_wen, mem_exc, mem_in_ds, fwd_valid;
  logic [31:0] mem_pc, mem_y, fwd_data;
  logic [4:0]  mem_rd, mem_excode, fwd_rd;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ex_mem_slave_reg dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_y(ex_y),
    .ex_overflow(ex_overflow), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_in_ds(ex_in_ds),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_y(mem_y),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_exc(mem_exc), .mem_excode(mem_excode),
    .mem_in_ds(mem_in_ds), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] y,
                       input logic ov, input logic [4:0] rd, input logic wen, input logic ds);
    ex_valid = v; ex_pc = pc; ex_y = y; ex_overflow = ov; ex_rd = rd; ex_wen = wen; ex_in_ds = ds;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick; tick;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
    checks++; if ({mem_y, mem_pc, mem_excode} !== 69'd0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_y, mem_pc, mem_excode); end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    mem_ready = 1'b1;
    drive(1'b1, 32'h100, 32'd1, 1'b0, 5'd1, 1'b1, 1'b1);
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'd1) begin errors++; $display("FAIL b2b_beat1 got v=%b y=%h exp v=1 y=1", mem_valid, mem_y); end
    checks++; if (mem_pc !== 32'h100 || mem_in_ds !== 1'b1 || mem_rd !== 5'd1) begin errors++; $display("FAIL b2b_fields got pc=%h ds=%b rd=%0d exp 100/1/1", mem_pc, mem_in_ds, mem_rd); end
    drive(1'b1, 32'h104, 32'd2, 1'b0, 5'd2, 1'b1, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'd2 || ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_beat2 got v=%b y=%h rdy=%b exp 1/2/1", mem_valid, mem_y, ex_ready); end
    drive(1'b1, 32'h108, 32'd3, 1'b0, 5'd3, 1'b1, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'd3 || ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_beat3 got v=%b y=%h rdy=%b exp 1/3/1", mem_valid, mem_y, ex_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", mem_valid); end
    tick;
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_no_effect got v=%b rdy=%b exp 0/1", mem_valid, ex_ready); end
  endtask

  task automatic test_skid;
    mem_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hA, 1'b0, 5'd10, 1'b1, 1'b0);
    tick;
    checks++; if (mem_y !== 32'hA || ex_ready !== 1'b1) begin errors++; $display("FAIL skid_A got y=%h rdy=%b exp A/1", mem_y, ex_ready); end
    drive(1'b1, 32'h204, 32'hB, 1'b0, 5'd11, 1'b1, 1'b0);
    tick;
    checks++; if (mem_y !== 32'hA || ex_ready !== 1'b0 || fwd_data !== 32'hB) begin errors++; $display("FAIL skid_B got y=%h rdy=%b fwd=%h exp A/0/B", mem_y, ex_ready, fwd_data); end
    drive(1'b1, 32'h208, 32'hC, 1'b0, 5'd12, 1'b1, 1'b0);
    tick;
    checks++; if (mem_y !== 32'hA || ex_ready !== 1'b0 || fwd_data !== 32'hB) begin errors++; $display("FAIL skid_C_held got y=%h rdy=%b fwd=%h exp A/0/B", mem_y, ex_ready, fwd_data); end
    mem_ready = 1'b1;
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'hB || ex_ready !== 1'b1) begin errors++; $display("FAIL skid_pop1 got v=%b y=%h rdy=%b exp 1/B/1", mem_valid, mem_y, ex_ready); end
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'hC) begin errors++; $display("FAIL skid_pop2 got v=%b y=%h exp 1/C", mem_valid, mem_y); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got=%b exp=0", mem_valid); end
  endtask

  task automatic test_overflow;
    mem_ready = 1'b0;
    drive(1'b1, 32'h300, 32'h80000000, 1'b1, 5'd8, 1'b1, 1'b0);
    tick;
    checks++; if (mem_exc !== 1'b1 || mem_excode !== 5'h0C || mem_wen !== 1'b0) begin errors++; $display("FAIL ov_head got exc=%b code=%h wen=%b exp 1/0c/0", mem_exc, mem_excode, mem_wen); end
    checks++; if (fwd_valid !== 1'b0 || ex_ready !== 1'b0 || mem_rd !== 5'd8) begin errors++; $display("FAIL ov_fwd_ready got fv=%b rdy=%b rd=%0d exp 0/0/8", fwd_valid, ex_ready, mem_rd); end
    drive(1'b1, 32'h304, 32'h55, 1'b0, 5'd9, 1'b1, 1'b0);
    mem_ready = 1'b1;
    tick;
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b0) begin errors++; $display("FAIL ov_after_pop got v=%b rdy=%b exp 0/0", mem_valid, ex_ready); end
    tick;
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b0) begin errors++; $display("FAIL ov_hold got v=%b rdy=%b exp 0/0", mem_valid, ex_ready); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++; if (ex_ready !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL ov_flush got rdy=%b v=%b exp 1/0", ex_ready, mem_valid); end
    drive(1'b1, 32'h308, 32'h66, 1'b0, 5'd9, 1'b1, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'h66 || mem_exc !== 1'b0) begin errors++; $display("FAIL ov_resume got v=%b y=%h exc=%b exp 1/66/0", mem_valid, mem_y, mem_exc); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_flush;
    mem_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h91, 1'b0, 5'd1, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'h404, 32'h92, 1'b0, 5'd2, 1'b1, 1'b0);
    tick;
    checks++; if (ex_ready !== 1'b0 || mem_valid !== 1'b1) begin errors++; $display("FAIL flush_full got rdy=%b v=%b exp 0/1", ex_ready, mem_valid); end
    drive(1'b1, 32'h408, 32'h99, 1'b0, 5'd3, 1'b1, 1'b0);
    mem_ready = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++; if (mem_valid !== 1'b0 || fwd_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL flush_clear got v=%b fv=%b rdy=%b exp 0/0/1", mem_valid, fwd_valid, ex_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_not_captured got=%b exp=0", mem_valid); end
    drive(1'b1, 32'h40C, 32'h0BAD, 1'b1, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL flush_ov_same got v=%b rdy=%b exp 0/1", mem_valid, ex_ready); end
    drive(1'b1, 32'h410, 32'h77, 1'b0, 5'd0, 1'b1, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'h77 || mem_rd !== 5'd0 || fwd_valid !== 1'b1) begin errors++; $display("FAIL flush_ov_run_rd0 got v=%b y=%h rd=%0d fv=%b exp 1/77/0/1", mem_valid, mem_y, mem_rd, fwd_valid); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_forwarding;
    mem_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h11, 1'b0, 5'd5, 1'b1, 1'b0);
    tick;
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h11) begin errors++; $display("FAIL fwd_h_only got v=%b rd=%0d d=%h exp 1/5/11", fwd_valid, fwd_rd, fwd_data); end
    drive(1'b1, 32'h504, 32'h22, 1'b0, 5'd6, 1'b1, 1'b0);
    tick;
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd6 || fwd_data !== 32'h22) begin errors++; $display("FAIL fwd_from_s got v=%b rd=%0d d=%h exp 1/6/22", fwd_valid, fwd_rd, fwd_data); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick;
    checks++; if (fwd_rd !== 5'd6 || fwd_data !== 32'h22 || mem_rd !== 5'd6) begin errors++; $display("FAIL fwd_after_pop got rd=%0d d=%h mrd=%0d exp 6/22/6", fwd_rd, fwd_data, mem_rd); end
    mem_ready = 1'b0;
    drive(1'b1, 32'h508, 32'h33, 1'b0, 5'd7, 1'b0, 1'b0);
    tick;
    checks++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd7) begin errors++; $display("FAIL fwd_s_nowen got v=%b rd=%0d exp 0/7", fwd_valid, fwd_rd); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick; tick;
  endtask

  task automatic test_async_reset;
    mem_ready = 1'b0;
    drive(1'b1, 32'h600, 32'hE1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'h604, 32'hE2, 1'b1, 5'd4, 1'b1, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b1 || ex_ready !== 1'b0) begin errors++; $display("FAIL areset_pre got v=%b rdy=%b exp 1/0", mem_valid, ex_ready); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1 || fwd_valid !== 1'b0 || mem_y !== 32'h0) begin errors++; $display("FAIL areset_immediate got v=%b rdy=%b fv=%b y=%h exp 0/1/0/0", mem_valid, ex_ready, fwd_valid, mem_y); end
    #1;
    resetn = 1'b1;
    drive(1'b1, 32'h608, 32'hE3, 1'b0, 5'd5, 1'b1, 1'b0);
    tick;
    checks++; if (mem_valid !== 1'b1 || mem_y !== 32'hE3 || ex_ready !== 1'b1) begin errors++; $display("FAIL areset_resume got v=%b y=%h rdy=%b exp 1/e3/1", mem_valid, mem_y, ex_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_skid;
    test_overflow;
    test_flush;
    test_forwarding;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
